// File: rtl/sdp_ram_reader.sv
// Streams COUNT consecutive entries from an sdp_ram read port onto an AXI-Stream master.
// A 2-entry output buffer hides the RAM's 1-cycle read latency and keeps 1 beat/clk.
module sdp_ram_reader #(
  parameter  int DW = 512,
  parameter  int DD = 16384,
  localparam int AW = $clog2(DD),
  localparam int CW = $clog2(DD + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addrb,
  input  logic [DW-1:0] ram_dob,
  output logic [DW-1:0] axis_tdata,
  output logic          axis_tvalid,
  output logic          axis_tlast,
  input  logic          axis_tready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] issue_rem_q, issue_rem_d;
  logic          inflight_q, inflight_d;
  logic          infl_last_q, infl_last_d;
  logic [1:0]    occ_q, occ_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;
  logic          last0_q, last0_d;
  logic          last1_q, last1_d;

  logic          pop_s;
  logic          push_s;
  logic          issue_s;

  // Buffer level counts the read in flight so a stalled stream never overflows it
  always_comb begin
    pop_s   = (occ_q != 2'd0) && axis_tready;
    push_s  = inflight_q;
    issue_s = (state_q == S_RUN) && (issue_rem_q != '0) &&
              (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));
  end

  // Command FSM and read-issue pointer
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    issue_rem_d = issue_rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_ptr_d    = start_addr;
          issue_rem_d = count;
          state_d     = (count == '0) ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (pop_s && last0_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
        if (issue_s) begin
          rd_ptr_d    = (rd_ptr_q == AW'(DD - 1)) ? '0 : rd_ptr_q + AW'(1);
          issue_rem_d = issue_rem_q - CW'(1);
        end else begin
          rd_ptr_d    = rd_ptr_q;
          issue_rem_d = issue_rem_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    inflight_d  = issue_s;
    infl_last_d = issue_s && (issue_rem_q == CW'(1));
  end

  // Output buffer: head in buf0, push captures ram_dob the cycle after its issue
  always_comb begin
    occ_d   = occ_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d  = ram_dob;
          last0_d = infl_last_q;
        end else begin
          buf1_d  = ram_dob;
          last1_d = infl_last_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d  = buf1_q;
        last0_d = last1_q;
        last1_d = 1'b0;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d  = ram_dob;
          last0_d = infl_last_q;
        end else begin
          buf0_d  = buf1_q;
          last0_d = last1_q;
          buf1_d  = ram_dob;
          last1_d = infl_last_q;
        end
      end
      default: occ_d = occ_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      issue_rem_q <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      issue_rem_q <= issue_rem_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign ram_addrb   = rd_ptr_q;
  assign axis_tdata  = buf0_q;
  assign axis_tvalid = (occ_q != 2'd0);
  assign axis_tlast  = last0_q;

endmodule

// File: tb/tb_sdp_ram_reader.sv
// Directed bench for sdp_ram_reader against a small registered-read RAM model (DD=16).
module tb_sdp_ram_reader;

  localparam int DW = 16;
  localparam int DD = 16;
  localparam int AW = $clog2(DD);
  localparam int CW = $clog2(DD + 1);

  logic          clk;
  logic          resetn;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_dob;
  logic [DW-1:0] axis_tdata;
  logic          axis_tvalid;
  logic          axis_tlast;
  logic          axis_tready;

  logic [DW-1:0] mem [DD];

  int n_assert = 0;
  int n_fail   = 0;

  sdp_ram_reader #(.DW(DW), .DD(DD)) dut (
    .clk(clk), .resetn(resetn), .start(start), .start_addr(start_addr),
    .count(count), .busy(busy), .done(done), .ram_addrb(ram_addrb),
    .ram_dob(ram_dob), .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid),
    .axis_tlast(axis_tlast), .axis_tready(axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM port B: registered read, data valid one clock after the address
  always @(posedge clk) ram_dob <= mem[ram_addrb];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input int a, input int c);
    start      = 1'b1;
    start_addr = AW'(a);
    count      = CW'(c);
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: tready high; mode 1: toggling tready with a 20-clk low stretch
  task automatic expect_stream(input int a, input int cnt, input int mode, input bit inject);
    int k = 0;
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    bit held = 1'b0;
    logic [DW-1:0] hv = '0;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (k < cnt && cyc < 400) begin
      if (mode == 0) axis_tready = 1'b1;
      else axis_tready = (cyc >= 4 && cyc < 24) ? 1'b0 : ((cyc % 3) != 1);
      if (inject && cyc == 3) begin
        start = 1'b1; start_addr = AW'(0); count = CW'(2);
      end else begin
        start = 1'b0;
      end
      if (held) begin
        chk("stall_valid", 32'(axis_tvalid), 32'd1);
        chk("stall_data", 32'(axis_tdata), 32'(hv));
      end
      if (axis_tvalid) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("data", 32'(axis_tdata), 32'((a + k) % DD));
        chk("last", 32'(axis_tlast), 32'(k == cnt - 1));
        held = !axis_tready;
        hv   = axis_tdata;
        if (axis_tready) begin
          k++;
          last_cyc = cyc;
        end
      end else begin
        held = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("beats", 32'(k), 32'(cnt));
    if (cnt > 0) chk("latency", 32'(first_cyc), 32'd2);
    if (cnt > 0 && mode == 0) chk("throughput", 32'(last_cyc - first_cyc), 32'(cnt - 1));
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("valid_in_done", 32'(axis_tvalid), 32'd0);
    @(negedge clk);
    chk("done_fall", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("valid_idle", 32'(axis_tvalid), 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < DD; i++) mem[i] = DW'(i);
    resetn = 1'b0; start = 1'b0; start_addr = '0; count = '0; axis_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(axis_tvalid), 32'd0);
    chk("rst_last", 32'(axis_tlast), 32'd0);
    chk("rst_addr", 32'(ram_addrb), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // T1 basic stream
    send_cmd(10, 4);
    expect_stream(10, 4, 0, 1'b0);
    // T2 address wrap
    send_cmd(14, 4);
    expect_stream(14, 4, 0, 1'b0);
    // T3 backpressure
    send_cmd(3, 8);
    expect_stream(3, 8, 1, 1'b0);
    // T4 zero count
    send_cmd(7, 0);
    expect_stream(7, 0, 0, 1'b0);
    // T5 start while busy ignored, then back-to-back command
    send_cmd(6, 5);
    expect_stream(6, 5, 0, 1'b1);
    send_cmd(15, 3);
    expect_stream(15, 3, 0, 1'b0);
    // T6 reset mid-stream, then a fresh command
    send_cmd(5, 8);
    axis_tready = 1'b1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (axis_tvalid && k == 3) break;
      if (axis_tvalid) k++;
      @(negedge clk);
    end
    chk("t6_reached_beat3", 32'(axis_tdata), 32'd8);
    #2 resetn = 1'b0;
    #1;
    chk("t6_valid", 32'(axis_tvalid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_addr", 32'(ram_addrb), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_no_done", 32'(done), 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_no_done_after", 32'(done), 32'd0);
    chk("t6_idle_valid", 32'(axis_tvalid), 32'd0);
    send_cmd(12, 3);
    expect_stream(12, 3, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
